seq_scan_sched: RTL
===================

# seq_scan_sched

Round-robin scheduler that shares one serial pattern-match engine among NCH bit-serial requester channels. Each granted channel streams a frame of `frame_len` bits through a valid/ready handshake. The engine flags every occurrence of the fixed pattern PATTERN, with overlap allowed. At frame end the block reports the per-frame hit count and the serving channel. It sits between the serial capture front-ends and the status/interrupt logic that previously used one dedicated detector per channel.

## Interface
- NCH, 4: number of requester channels (2..8)
- PAT_W, 5: pattern length in bits
- PATTERN, 5'b11101: pattern matched; MSB is the oldest bit
- LEN_W, 8: width of frame length and hit counter
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NCH  per-channel frame request
- frame_len  in  NCH*LEN_W  per-channel frame length in bits; channel k occupies bits [k*LEN_W +: LEN_W]
- bit_i  in  NCH  per-channel serial data bit
- bit_vld  in  NCH  per-channel data valid
- bit_rdy  out  NCH  one-hot; high only for the granted channel while streaming
- gnt  out  NCH  one-hot grant, held for the whole frame
- busy  out  1  high in STREAM and DONE
- hit  out  1  one-cycle pulse per pattern match
- done  out  1  one-cycle end-of-frame pulse
- done_ch  out  $clog2(NCH)  channel just served; valid with `done`, held until next `done`
- hit_cnt  out  LEN_W  hits in the frame; valid with `done`, held until next `done`

## Operation
- **States.** IDLE, STREAM, DONE.
- **IDLE.**
  - If any `req` is high, select the first requesting channel searching upward (with wrap) from `ptr`.
  - Latch the channel index and its `frame_len`.
  - Clear the match history and the running hit count.
  - Go to STREAM, or to DONE if the latched length is 0.
  - With no requests, stay in IDLE.
- **STREAM.**
  - `gnt[ch]` and `bit_rdy[ch]` are high.
  - A bit is accepted when `bit_vld[ch] && bit_rdy[ch]`.
  - Each accepted bit shifts into the history and decrements the remaining count.
  - Other channels' `bit_vld` and `bit_i` are ignored.
  - On accepting the last bit, go to DONE.
- **Match rule.** A hit occurs on an accepted bit when the frame has accepted at least PAT_W bits and the last PAT_W accepted bits equal PATTERN.
  - Overlapping matches count.
  - History never spans frames.
- **DONE.**
  - `done`=1 for one cycle; `hit_cnt` and `done_ch` are updated in the same cycle.
  - `gnt` and `bit_rdy` are 0.
  - `ptr` becomes ch+1 mod NCH.
  - Next state is IDLE.
- **Request rules.**
  - `req` is sampled only in IDLE.
  - Dropping `req` mid-frame does not abort the frame.
  - A requester whose `req` is still high after `done` re-competes at the new `ptr` priority.
- **Counter width.** `hit_cnt` cannot exceed `frame_len` - PAT_W + 1, so LEN_W bits suffice; no saturation logic is needed.
- **Reset values.**
  - All outputs are 0.
  - `ptr`=0 (channel 0 has highest priority).
  - State is IDLE and history is cleared.
  - Reset mid-frame abandons the frame with no `done`.

## Timing
- **Arbitration latency.** `req` seen high in IDLE at edge n → `gnt`/`bit_rdy` high from edge n+1.
- **Hit.** `hit` is registered: it pulses in the cycle after the accepting edge of the completing bit.
- **Done.** `done` is high in the cycle after the last bit is accepted. The final `hit` pulse coincides with `done`, and `hit_cnt` already includes it.
- **Zero-length frame.** `done` comes one cycle after the IDLE decision; `bit_rdy` never rises.
- **Throughput.** With `bit_vld` held high, a frame of L bits occupies L STREAM cycles + 1 DONE cycle + 1 IDLE cycle, i.e. L+2 cycles per frame.
- **Stalls.** `bit_vld` gaps do not disturb history or count.

## Structure
- **Package `seq_sched_pkg`.** State enum (IDLE/STREAM/DONE), default PATTERN/PAT_W constants, and a round-robin pick function.
- **Sub-module `pat_match`.**
  - Ports: clk, rst, clr, shift_en, bit_in, hit.
  - Contains the PAT_W-bit shift register and the fill counter.
  - Parameterised by PAT_W and PATTERN.
  - Instantiated once.

## Test plan
- **Overlap.** ch0 only, `frame_len`=10, bits 1110111101 with `bit_vld` held high → `hit` pulses after bits 5 and 10; `done` with `hit_cnt`=2, `done_ch`=0.
- **Round-robin.**
  - After reset, `req`=4'b1010 held → ch1 served first, then ch3.
  - Then `req`=4'b1111 → ch0 served next.
- **Zero length.** ch2 with `frame_len`=0 → `done` one cycle after the IDLE decision, `hit_cnt`=0, `bit_rdy` never high.
- **Stalls.** ch0, `frame_len`=5, bits 11101 with 3 idle `bit_vld` cycles between each bit → exactly one `hit`, `hit_cnt`=1.
- **Reset mid-frame.** Assert `rst` in STREAM after 3 bits → next cycle all outputs 0 and no `done`. A subsequent ch0 frame 11101 gives `hit_cnt`=1, proving the history was cleared.
- **Isolation.** ch1 granted while ch0 toggles `bit_vld`/`bit_i` → ch0 data has no effect; ch1 frame 01110 gives `hit_cnt`=0.

Source files
------------

// File: rtl/seq_scan_sched_pkg.sv
// Shared types and helpers for the round-robin serial pattern-match scheduler.
package seq_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } state_t;

  localparam int                   MAX_CH      = 8;
  localparam int                   DEF_PAT_W   = 5;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 5'b11101;

  // First requesting channel at or above ptr, wrapping within n channels.
  function automatic logic [2:0] rr_pick(input logic [MAX_CH-1:0] req,
                                         input logic [2:0]        ptr,
                                         input int                n);
    logic       found;
    logic [2:0] idx;
    rr_pick = '0;
    found   = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      idx = 3'((int'(ptr) + i) % n);
      if (i < n && !found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/seq_scan_sched_if.sv
// Requester-side bundle of the scheduler: per-channel request, length and serial data plus status.
interface seq_scan_sched_if #(
  parameter int NCH   = 4,
  parameter int LEN_W = 8
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]       req;
  logic [NCH*LEN_W-1:0] frame_len;
  logic [NCH-1:0]       bit_i;
  logic [NCH-1:0]       bit_vld;
  logic [NCH-1:0]       bit_rdy;
  logic [NCH-1:0]       gnt;
  logic                 busy;
  logic                 hit;
  logic                 done;
  logic [CW-1:0]        done_ch;
  logic [LEN_W-1:0]     hit_cnt;

  modport master (
    output req, frame_len, bit_i, bit_vld,
    input  bit_rdy, gnt, busy, hit, done, done_ch, hit_cnt
  );

  modport slave (
    input  req, frame_len, bit_i, bit_vld,
    output bit_rdy, gnt, busy, hit, done, done_ch, hit_cnt
  );

endinterface

// File: rtl/seq_scan_sched_pat_match.sv
// Serial matcher: flags the completing bit of every (overlapping) PATTERN occurrence, one cycle late.
module pat_match
  import seq_sched_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic shift_en,
  input  logic bit_in,
  output logic hit
);
  localparam int FW = $clog2(PAT_W + 1);

  logic [PAT_W-2:0] r_sh;
  logic [FW-1:0]    r_fill;
  logic             r_hit;
  logic [PAT_W-1:0] w_sh_nxt;

  assign w_sh_nxt = {r_sh, bit_in};

  // r_fill saturates at PAT_W so a match needs a full window from this frame.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_sh   <= '0;
      r_fill <= '0;
      r_hit  <= 1'b0;
    end else if (shift_en) begin
      r_sh <= w_sh_nxt[PAT_W-2:0];
      if (r_fill != FW'(PAT_W)) r_fill <= r_fill + FW'(1);
      r_hit <= (r_fill >= FW'(PAT_W - 1)) && (w_sh_nxt == PATTERN);
    end else begin
      r_hit <= 1'b0;
    end
  end

  assign hit = r_hit;

endmodule

// File: rtl/seq_scan_sched.sv
// Round-robin sharing of one serial pattern matcher among NCH requesters.
// States: IDLE arbitrate and latch length | STREAM shift granted bits | DONE report, advance ptr.
module seq_scan_sched
  import seq_sched_pkg::*;
#(
  parameter int               NCH     = 4,
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               LEN_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  seq_scan_sched_if.slave   bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_ch, r_ptr, r_done_ch, w_pick, w_ch_nxt;
  logic [LEN_W-1:0] r_rem, r_cnt, r_hit_cnt, w_len_sel, w_hit_cnt;
  logic [NCH-1:0]   w_onehot;
  logic             w_any_req, w_acc, w_last, w_hit;

  assign w_any_req = |bus.req;
  assign w_pick    = CW'(rr_pick(MAX_CH'(bus.req), 3'(r_ptr), NCH));
  assign w_len_sel = bus.frame_len[int'(w_pick)*LEN_W +: LEN_W];
  assign w_acc     = (r_state == ST_STREAM) && bus.bit_vld[r_ch];
  assign w_last    = (r_rem == LEN_W'(1));
  assign w_onehot  = NCH'(1) << r_ch;
  assign w_ch_nxt  = (r_ch == CW'(NCH - 1)) ? '0 : r_ch + CW'(1);
  // The last bit's hit lands in the DONE cycle, so fold it in combinationally there.
  assign w_hit_cnt = r_cnt + LEN_W'(w_hit);

  pat_match #(.PAT_W(PAT_W), .PATTERN(PATTERN)) u_match (
    .clk     (clk),
    .rst     (rst),
    .clr     (r_state == ST_IDLE),
    .shift_en(w_acc),
    .bit_in  (bus.bit_i[r_ch]),
    .hit     (w_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ch      <= '0;
      r_ptr     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_done_ch <= '0;
      r_hit_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_any_req) begin
            r_ch  <= w_pick;
            r_rem <= w_len_sel;
          end
        end
        ST_STREAM: begin
          if (w_acc) r_rem <= r_rem - LEN_W'(1);
          r_cnt <= w_hit_cnt;
        end
        ST_DONE: begin
          r_ptr     <= w_ch_nxt;
          r_done_ch <= r_ch;
          r_hit_cnt <= w_hit_cnt;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    bus.gnt      = '0;
    bus.bit_rdy  = '0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.done_ch  = r_done_ch;
    bus.hit_cnt  = r_hit_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_state_nxt = (w_len_sel == '0) ? ST_DONE : ST_STREAM;
      end
      ST_STREAM: begin
        bus.gnt     = w_onehot;
        bus.bit_rdy = w_onehot;
        bus.busy    = 1'b1;
        if (w_acc && w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.busy    = 1'b1;
        bus.done    = 1'b1;
        bus.done_ch = r_ch;
        bus.hit_cnt = w_hit_cnt;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.hit = w_hit;

endmodule
